// File: rtl/regfile_scheduler_pkg.sv
// Shared widths, FSM states and requester ids for the register-file port scheduler.
// Pure declarations: no logic, no latency, no backpressure.
package regfile_scheduler_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic {
    SCRUB,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    WB0,
    WB1,
    RD
  } req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; combinational grant, registered priority pointer.
// Pointer advances only when the caller actually consumes the grant (update=1).
module rr_arbiter2
  import regfile_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic gnt0,
  output logic gnt1
);

  // prio_q names the requester that wins the next tie.
  req_id_t prio_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = (prio_q == WB0);
      gnt1 = (prio_q != WB0);
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q <= WB0;
    end else if (update && (gnt0 || gnt1)) begin
      prio_q <= gnt0 ? WB1 : WB0;
    end
  end

endmodule

// File: rtl/regfile_scheduler.sv
// Single-port register-file scheduler: zero-fill after reset, then one write or one read per cycle.
// Writes complete in the grant cycle; read data returns one cycle after rd_ready; readies are grants.
module regfile_scheduler #(
  parameter int DATA_W       = regfile_scheduler_pkg::DATA_W,
  parameter int ADDR_W       = regfile_scheduler_pkg::ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_ra,
  input  logic [ADDR_W-1:0] rd_rb,
  output logic              rd_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_a,
  output logic [DATA_W-1:0] resp_b,
  output logic              scrub_done,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_register,
  output logic [DATA_W-1:0] rf_busW,
  output logic [ADDR_W-1:0] rf_RA,
  output logic [ADDR_W-1:0] rf_RB,
  input  logic [DATA_W-1:0] rf_busA,
  input  logic [DATA_W-1:0] rf_busB
);

  import regfile_scheduler_pkg::*;

  localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] scrub_ptr_q;
  logic [CNT_W-1:0]  starve_q;
  logic [ADDR_W-1:0] ra_hold_q, rb_hold_q;
  logic              ra_zero_q, rb_zero_q;
  logic              resp_valid_q, scrub_done_q;

  logic arb_gnt0, arb_gnt1;
  logic run, raw_block, forced_rd, wr_any, wr_grant, rd_grant;

  // Holding rst low suppresses every grant, so a read in flight at reset never responds.
  assign run = rst && (state_q == RUN);

  assign raw_block =
      (wb0_valid && (wb0_addr != '0) && ((wb0_addr == rd_ra) || (wb0_addr == rd_rb))) ||
      (wb1_valid && (wb1_addr != '0) && ((wb1_addr == rd_ra) || (wb1_addr == rd_rb)));

  assign forced_rd = rd_valid && (starve_q == STARVE_MAX) && !raw_block;
  assign wr_any    = wb0_valid || wb1_valid;
  assign wr_grant  = run && wr_any && !forced_rd;
  assign rd_grant  = run && rd_valid && (forced_rd || !wr_any);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req0   (wb0_valid),
    .req1   (wb1_valid),
    .update (wr_grant),
    .gnt0   (arb_gnt0),
    .gnt1   (arb_gnt1)
  );

  assign wb0_ready = wr_grant && arb_gnt0;
  assign wb1_ready = wr_grant && arb_gnt1;
  assign rd_ready  = rd_grant;

  always_comb begin
    state_d           = state_q;
    rf_write_enable   = 1'b0;
    rf_write_register = '0;
    rf_busW           = '0;
    case (state_q)
      SCRUB: begin
        if (rst) begin
          rf_write_enable   = 1'b1;
          rf_write_register = scrub_ptr_q;
          if (scrub_ptr_q == '1) state_d = RUN;
        end
      end
      RUN: begin
        // $0 writes are acknowledged but never reach the file.
        if (wb0_ready) begin
          rf_write_enable   = (wb0_addr != '0);
          rf_write_register = wb0_addr;
          rf_busW           = wb0_data;
        end else if (wb1_ready) begin
          rf_write_enable   = (wb1_addr != '0);
          rf_write_register = wb1_addr;
          rf_busW           = wb1_data;
        end
      end
      default: state_d = SCRUB;
    endcase
  end

  assign rf_RA = rd_grant ? rd_ra : ra_hold_q;
  assign rf_RB = rd_grant ? rd_rb : rb_hold_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= SCRUB;
      scrub_ptr_q  <= '0;
      starve_q     <= '0;
      ra_hold_q    <= '0;
      rb_hold_q    <= '0;
      ra_zero_q    <= 1'b0;
      rb_zero_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      scrub_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= rd_grant;
      if (state_q == SCRUB) begin
        scrub_ptr_q <= scrub_ptr_q + 1'b1;
        if (scrub_ptr_q == '1) scrub_done_q <= 1'b1;
      end
      if (rd_grant) begin
        ra_hold_q <= rd_ra;
        rb_hold_q <= rd_rb;
        ra_zero_q <= (rd_ra == '0);
        rb_zero_q <= (rd_rb == '0);
      end
      if (!rd_valid || rd_grant) begin
        starve_q <= '0;
      end else if (wr_grant && (starve_q != STARVE_MAX)) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  // The file registered its read buses at the grant edge, so they are already stable here.
  assign resp_valid = resp_valid_q;
  assign resp_a     = (resp_valid_q && !ra_zero_q) ? rf_busA : '0;
  assign resp_b     = (resp_valid_q && !rb_zero_q) ? rf_busB : '0;
  assign scrub_done = scrub_done_q;

endmodule

// File: tb/tb_regfile_scheduler.sv
// Directed bench for regfile_scheduler with a behavioural 32x32 register file attached.
module tb_regfile_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb0_valid, wb1_valid, rd_valid;
  logic [4:0]  wb0_addr, wb1_addr, rd_ra, rd_rb;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready, rd_ready;
  logic        resp_valid, scrub_done;
  logic [31:0] resp_a, resp_b;
  logic        rf_write_enable;
  logic [4:0]  rf_write_register, rf_RA, rf_RB;
  logic [31:0] rf_busW, rf_busA, rf_busB;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .wb0_valid         (wb0_valid),
    .wb0_addr          (wb0_addr),
    .wb0_data          (wb0_data),
    .wb0_ready         (wb0_ready),
    .wb1_valid         (wb1_valid),
    .wb1_addr          (wb1_addr),
    .wb1_data          (wb1_data),
    .wb1_ready         (wb1_ready),
    .rd_valid          (rd_valid),
    .rd_ra             (rd_ra),
    .rd_rb             (rd_rb),
    .rd_ready          (rd_ready),
    .resp_valid        (resp_valid),
    .resp_a            (resp_a),
    .resp_b            (resp_b),
    .scrub_done        (scrub_done),
    .rf_write_enable   (rf_write_enable),
    .rf_write_register (rf_write_register),
    .rf_busW           (rf_busW),
    .rf_RA             (rf_RA),
    .rf_RB             (rf_RB),
    .rf_busA           (rf_busA),
    .rf_busB           (rf_busB)
  );

  logic [31:0] rf_mem [0:31];

  always @(posedge clk) begin
    if (rf_write_enable) rf_mem[rf_write_register] <= rf_busW;
    rf_busA <= rf_mem[rf_RA];
    rf_busB <= rf_mem[rf_RB];
  end

  task automatic idle_inputs();
    wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
    rd_valid  = 1'b0; rd_ra    = '0; rd_rb    = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rf_write_enable, wb0_ready, wb1_ready, rd_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: we/r0/r1/rd=%b expected 0000",
               {rf_write_enable, wb0_ready, wb1_ready, rd_ready});
    end
    vectors++;
    if ({resp_valid, scrub_done} !== 2'b00 || resp_a !== 32'h0 || resp_b !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_resp: resp_valid=%b scrub_done=%b resp_a=%h resp_b=%h expected all 0",
               resp_valid, scrub_done, resp_a, resp_b);
    end
  endtask

  task automatic test_scrub();
    // Requests held valid throughout: none may be acknowledged while scrubbing.
    wb0_valid = 1'b1; wb1_valid = 1'b1; rd_valid = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      vectors++;
      if (rf_write_enable !== 1'b1 || rf_write_register !== 5'(i) || rf_busW !== 32'h0) begin
        miscompares++;
        $display("FAIL scrub_write%0d: we=%b reg=%0d busW=%h expected 1/%0d/0",
                 i, rf_write_enable, rf_write_register, rf_busW, i);
      end
      vectors++;
      if ({wb0_ready, wb1_ready, rd_ready, scrub_done} !== 4'b0000) begin
        miscompares++;
        $display("FAIL scrub_ready%0d: r0/r1/rd/done=%b expected 0000",
                 i, {wb0_ready, wb1_ready, rd_ready, scrub_done});
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    vectors++;
    if (scrub_done !== 1'b1 || rf_write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL scrub_done: scrub_done=%b we=%b expected 1/0", scrub_done, rf_write_enable);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_w0;
    exp_w0 = 4'b0101;
    wb0_valid = 1'b1; wb0_addr = 5'd10; wb0_data = 32'h100;
    wb1_valid = 1'b1; wb1_addr = 5'd11; wb1_data = 32'h200;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (wb0_ready !== exp_w0[k] || wb1_ready !== !exp_w0[k] ||
          rf_write_register !== (exp_w0[k] ? 5'd10 : 5'd11)) begin
        miscompares++;
        $display("FAIL rr_grant%0d: wb0_ready=%b wb1_ready=%b reg=%0d expected %b/%b",
                 k, wb0_ready, wb1_ready, rf_write_register, exp_w0[k], !exp_w0[k]);
      end
      @(negedge clk);
      if (exp_w0[k]) wb0_data = wb0_data + 1; else wb1_data = wb1_data + 1;
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    #1;
    vectors++;
    if (wb0_ready !== 1'b1 || rf_write_enable !== 1'b1 || rf_write_register !== 5'd5 ||
        rf_busW !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL wr_r5: ready=%b we=%b reg=%0d busW=%h expected 1/1/5/deadbeef",
               wb0_ready, rf_write_enable, rf_write_register, rf_busW);
    end
    @(negedge clk);
    idle_inputs();
    rd_valid = 1'b1; rd_ra = 5'd5; rd_rb = 5'd0;
    #1;
    vectors++;
    if (rd_ready !== 1'b1 || rf_write_enable !== 1'b0 || rf_RA !== 5'd5 || rf_RB !== 5'd0) begin
      miscompares++;
      $display("FAIL rd_grant: rd_ready=%b we=%b RA=%0d RB=%0d expected 1/0/5/0",
               rd_ready, rf_write_enable, rf_RA, rf_RB);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (resp_valid !== 1'b1 || resp_a !== 32'hDEADBEEF || resp_b !== 32'h0) begin
      miscompares++;
      $display("FAIL rd_resp: valid=%b a=%h b=%h expected 1/deadbeef/0", resp_valid, resp_a, resp_b);
    end
    vectors++;
    if (rf_RA !== 5'd5) begin
      miscompares++;
      $display("FAIL ra_hold: RA=%0d expected 5", rf_RA);
    end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL resp_pulse: resp_valid=%b expected 0", resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    wb1_valid = 1'b1; wb1_addr = 5'd6; wb1_data = 32'h66;
    @(negedge clk);
    idle_inputs();
    rd_valid = 1'b1; rd_ra = 5'd5; rd_rb = 5'd6;
    #1;
    vectors++;
    if (rd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: rd_ready=%b expected 1", rd_ready);
    end
    @(negedge clk);
    rd_ra = 5'd6; rd_rb = 5'd5;
    #1;
    vectors++;
    if (rd_ready !== 1'b1 || resp_valid !== 1'b1 || resp_a !== 32'hDEADBEEF || resp_b !== 32'h66) begin
      miscompares++;
      $display("FAIL b2b_resp1: rdy=%b valid=%b a=%h b=%h expected 1/1/deadbeef/66",
               rd_ready, resp_valid, resp_a, resp_b);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (resp_valid !== 1'b1 || resp_a !== 32'h66 || resp_b !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL b2b_resp2: valid=%b a=%h b=%h expected 1/66/deadbeef", resp_valid, resp_a, resp_b);
    end
    @(negedge clk);
  endtask

  task automatic test_starve();
    rd_valid  = 1'b1; rd_ra = 5'd3; rd_rb = 5'd3;
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h1;
    wb1_valid = 1'b1; wb1_addr = 5'd8; wb1_data = 32'h2;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (k < 4 && (rd_ready !== 1'b0 || (wb0_ready | wb1_ready) !== 1'b1)) begin
        miscompares++;
        $display("FAIL starve_wr%0d: rd_ready=%b wb0=%b wb1=%b expected write grant",
                 k, rd_ready, wb0_ready, wb1_ready);
      end else if (k == 4 && (rd_ready !== 1'b1 || wb0_ready !== 1'b0 || wb1_ready !== 1'b0)) begin
        miscompares++;
        $display("FAIL starve_forced: rd_ready=%b wb0=%b wb1=%b expected 1/0/0",
                 rd_ready, wb0_ready, wb1_ready);
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    vectors++;
    if (resp_valid !== 1'b1 || resp_a !== 32'h0 || resp_b !== 32'h0) begin
      miscompares++;
      $display("FAIL starve_resp: valid=%b a=%h b=%h expected 1/0/0", resp_valid, resp_a, resp_b);
    end
    @(negedge clk);
  endtask

  task automatic test_raw_block();
    rd_valid  = 1'b1; rd_ra = 5'd2; rd_rb = 5'd7;
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h77;
    for (int k = 0; k < 6; k++) begin
      #1;
      vectors++;
      if (rd_ready !== 1'b0 || wb0_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL raw_hold%0d: rd_ready=%b wb0_ready=%b expected 0/1", k, rd_ready, wb0_ready);
      end
      @(negedge clk);
    end
    wb0_valid = 1'b0;
    #1;
    vectors++;
    if (rd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL raw_release: rd_ready=%b expected 1", rd_ready);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (resp_valid !== 1'b1 || resp_a !== 32'h0 || resp_b !== 32'h77) begin
      miscompares++;
      $display("FAIL raw_resp: valid=%b a=%h b=%h expected 1/0/77", resp_valid, resp_a, resp_b);
    end
    @(negedge clk);
    wb1_valid = 1'b1; wb1_addr = 5'd9; wb1_data = 32'h99;
    rd_valid  = 1'b1; rd_ra = 5'd9; rd_rb = 5'd5;
    #1;
    vectors++;
    if (wb1_ready !== 1'b1 || rd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL raw_wb1: wb1_ready=%b rd_ready=%b expected 1/0", wb1_ready, rd_ready);
    end
    @(negedge clk);
    wb1_valid = 1'b0;
    #1;
    vectors++;
    if (rd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL raw_wb1_release: rd_ready=%b expected 1", rd_ready);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (resp_a !== 32'h99 || resp_b !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL raw_wb1_resp: a=%h b=%h expected 99/deadbeef", resp_a, resp_b);
    end
    @(negedge clk);
  endtask

  task automatic test_r0_write();
    wb0_valid = 1'b1; wb0_addr = 5'd0; wb0_data = 32'h1234;
    #1;
    vectors++;
    if (wb0_ready !== 1'b1 || rf_write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL r0_write: wb0_ready=%b we=%b expected 1/0", wb0_ready, rf_write_enable);
    end
    @(negedge clk);
    idle_inputs();
    rd_valid = 1'b1; rd_ra = 5'd0; rd_rb = 5'd9;
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (resp_valid !== 1'b1 || resp_a !== 32'h0 || resp_b !== 32'h99) begin
      miscompares++;
      $display("FAIL r0_read: valid=%b a=%h b=%h expected 1/0/99", resp_valid, resp_a, resp_b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    rd_valid = 1'b1; rd_ra = 5'd5; rd_rb = 5'd6;
    #1;
    vectors++;
    if (rd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre: rd_ready=%b expected 1", rd_ready);
    end
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (rd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_gate: rd_ready=%b expected 0", rd_ready);
    end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0 || scrub_done !== 1'b0 || resp_a !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_resp: valid=%b done=%b a=%h expected 0/0/0", resp_valid, scrub_done, resp_a);
    end
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (rf_write_enable !== 1'b1 || rf_write_register !== 5'(i)) begin
        miscompares++;
        $display("FAIL midrst_scrub%0d: we=%b reg=%0d expected 1/%0d", i, rf_write_enable, rf_write_register, i);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_scrub();
    test_round_robin();
    test_write_read();
    test_back_to_back();
    test_starve();
    test_raw_block();
    test_r0_write();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
